// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencing logic.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } spi_state_e;

   localparam int SPI_BITS            = 8;
   localparam int SPI_HALF_PERIODS    = 16;
   localparam int SPI_HALF_W          = 4;
   localparam int SPI_CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Down-counting divider: emits a terminal-count tick every CLK_DIV enabled cycles.
module spi_clk_div #(
   parameter int CLK_DIV = 4,
   parameter int W       = $clog2(CLK_DIV + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RELOAD;
      end else if (clr) begin
         cnt <= RELOAD;
      end else if (en) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_sequencer.sv
// Mode-0 SPI sequencer: drives load strobe, chip select and shift clock for one byte per start.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, outputs held
// ST_LOAD  | two cycles: ld_data settles, then b0 low for one cycle
// ST_SETUP | CS low, clkSeq low for CLK_DIV cycles before first edge
// ST_SHIFT | 16 half-periods, even ones high, odd ones low
// ST_HOLD  | CS low, clkSeq low for CLK_DIV cycles, then capture rm
module spi_sequencer
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic [SPI_BITS-1:0] rm,
   output logic [SPI_BITS-1:0] ld_data,
   output logic                b0,
   output logic                clkSeq,
   output logic                CS,
   output logic                busy,
   output logic                done,
   output logic [SPI_BITS-1:0] rx_data
);

   localparam logic [SPI_HALF_W-1:0] HALF_LAST = SPI_HALF_W'(SPI_HALF_PERIODS - 1);

   spi_state_e            state, state_nx;
   logic [SPI_HALF_W-1:0] half_cnt, half_nx;
   logic                  div_en, div_clr, tick;

   logic [SPI_BITS-1:0] ld_data_d, rx_data_d;
   logic                b0_d, clk_seq_d, cs_d, busy_d, done_d;

   assign div_en  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
   assign div_clr = (state_nx != state);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (div_en),
      .clr   (div_clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         half_cnt <= '0;
         ld_data  <= '0;
         b0       <= 1'b1;
         clkSeq   <= 1'b0;
         CS       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
      end else begin
         state    <= state_nx;
         half_cnt <= half_nx;
         ld_data  <= ld_data_d;
         b0       <= b0_d;
         clkSeq   <= clk_seq_d;
         CS       <= cs_d;
         busy     <= busy_d;
         done     <= done_d;
         rx_data  <= rx_data_d;
      end
   end

   // half_cnt doubles as the LOAD cycle index; it clears on every state entry
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_LOAD;
         ST_LOAD:  if (half_cnt == SPI_HALF_W'(1)) state_nx = ST_SETUP;
         ST_SETUP: if (tick) state_nx = ST_SHIFT;
         ST_SHIFT: if (tick && (half_cnt == HALF_LAST)) state_nx = ST_HOLD;
         ST_HOLD:  if (tick) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase

      half_nx = half_cnt;
      if (state_nx != state) begin
         half_nx = '0;
      end else if (state == ST_LOAD) begin
         half_nx = half_cnt + 1'b1;
      end else if ((state == ST_SHIFT) && tick) begin
         half_nx = half_cnt + 1'b1;
      end
   end

   always_comb begin
      ld_data_d = ld_data;
      rx_data_d = rx_data;
      b0_d      = b0;
      clk_seq_d = clkSeq;
      cs_d      = CS;
      busy_d    = busy;
      done_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               ld_data_d = tx_data;
               busy_d    = 1'b1;
            end
         end
         ST_LOAD: begin
            if (half_cnt == '0) begin
               b0_d = 1'b0;
            end else begin
               b0_d = 1'b1;
               cs_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick) clk_seq_d = 1'b1;
         end
         ST_SHIFT: begin
            // next half-period is high when the current one is odd
            if (tick) clk_seq_d = (half_cnt == HALF_LAST) ? 1'b0 : half_cnt[0];
         end
         ST_HOLD: begin
            if (tick) begin
               rx_data_d = rm;
               cs_d      = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
            end
         end
         default: begin
            b0_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_sequencer.sv
// Bench for spi_sequencer at CLK_DIV=2 and CLK_DIV=1 with a behavioural shift register.
module tb_spi_sequencer;

   localparam int DIV_A = 2;
   localparam int DIV_B = 1;
   localparam int LAT_A = 2 + 18 * DIV_A;
   localparam int LAT_B = 2 + 18 * DIV_B;

   typedef struct {
      logic [7:0] rx;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_err = 0;
   int n_checks = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // instance A, CLK_DIV=2
   logic       start_a = 1'b0;
   logic [7:0] tx_a = 8'h00;
   logic [7:0] rm_a, ld_a, rx_a;
   logic       b0_a, clk_seq_a, cs_a, busy_a, done_a;

   spi_sequencer #(.CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .rm(rm_a),
      .ld_data(ld_a), .b0(b0_a), .clkSeq(clk_seq_a), .CS(cs_a),
      .busy(busy_a), .done(done_a), .rx_data(rx_a)
   );

   // instance B, CLK_DIV=1
   logic       start_b = 1'b0;
   logic [7:0] tx_b = 8'h00;
   logic [7:0] rm_b, ld_b, rx_b;
   logic       b0_b, clk_seq_b, cs_b, busy_b, done_b;

   spi_sequencer #(.CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .rm(rm_b),
      .ld_data(ld_b), .b0(b0_b), .clkSeq(clk_seq_b), .CS(cs_b),
      .busy(busy_b), .done(done_b), .rx_data(rx_b)
   );

   // shift register models: parallel load on b0 low, sample MISO on clkSeq rise, LSB first
   int         miso_mode = 0;
   logic [7:0] sr_a = 8'h00, sr_b = 8'h00;
   logic       sq_a = 1'b0, sq_b = 1'b0;
   logic       mosi_a, miso_a, mosi_b;
   logic       mosi_log[$];

   assign mosi_a = sr_a[0];
   assign miso_a = (miso_mode == 0) ? mosi_a : (miso_mode == 1);
   assign rm_a   = sr_a;
   assign mosi_b = sr_b[0];
   assign rm_b   = sr_b;

   always @(posedge clk) begin
      sq_a <= clk_seq_a;
      if (!b0_a) sr_a <= ld_a;
      else if (clk_seq_a && !sq_a) begin
         sr_a <= {miso_a, sr_a[7:1]};
         mosi_log.push_back(mosi_a);
      end
      sq_b <= clk_seq_b;
      if (!b0_b) sr_b <= ld_b;
      else if (clk_seq_b && !sq_b) sr_b <= {mosi_b, sr_b[7:1]};
   end

   exp_t sb_a[$];
   exp_t sb_b[$];

   int   rises_a = 0, high_a = 0, b0lo_a = 0, outside_a = 0;
   logic busy_q_a = 1'b0, seq_n_a = 1'b0, b0_prev_a = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (busy_a && !busy_q_a) begin
         rises_a = 0; high_a = 0; b0lo_a = 0; outside_a = 0;
      end
      if (!cs_a && clk_seq_a && !seq_n_a) rises_a++;
      if (clk_seq_a) high_a++;
      if (clk_seq_a && cs_a) outside_a++;
      if (b0_prev_a) check("a_cs_after_b0", {b0_a, cs_a}, 2'b10);
      if (!b0_a) begin
         b0lo_a++;
         check("a_cs_during_b0", cs_a, 1);
      end
      if (done_a) begin
         if (sb_a.size() == 0) check("a_unexpected_done", done_a, 0);
         else begin
            e = sb_a.pop_front();
            check("a_rx", rx_a, e.rx);
            check("a_latency", cyc, e.cyc);
            check("a_busy_fall", busy_a, 0);
            check("a_cs_high", cs_a, 1);
            check("a_rises", rises_a, 8);
            check("a_high_cycles", high_a, 8 * DIV_A);
            check("a_b0_low_cycles", b0lo_a, 1);
            check("a_sclk_outside_cs", outside_a, 0);
         end
      end
      busy_q_a  = busy_a;
      seq_n_a   = clk_seq_a;
      b0_prev_a = !b0_a;
   end

   int   rises_b = 0, high_b = 0, b0lo_b = 0;
   logic busy_q_b = 1'b0, seq_n_b = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (busy_b && !busy_q_b) begin
         rises_b = 0; high_b = 0; b0lo_b = 0;
      end
      if (!cs_b && clk_seq_b && !seq_n_b) rises_b++;
      if (clk_seq_b) high_b++;
      if (!b0_b) b0lo_b++;
      if (done_b) begin
         if (sb_b.size() == 0) check("b_unexpected_done", done_b, 0);
         else begin
            e = sb_b.pop_front();
            check("b_rx", rx_b, e.rx);
            check("b_latency", cyc, e.cyc);
            check("b_busy_fall", busy_b, 0);
            check("b_rises", rises_b, 8);
            check("b_high_cycles", high_b, 8 * DIV_B);
            check("b_b0_low_cycles", b0lo_b, 1);
         end
      end
      busy_q_b = busy_b;
      seq_n_b  = clk_seq_b;
   end

   task automatic go_a(input logic [7:0] tx, input logic [7:0] exp_rx, output int n0);
      exp_t e;
      @(negedge clk);
      tx_a = tx; start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      n0 = cyc;
      e.rx = exp_rx; e.cyc = n0 + LAT_A;
      sb_a.push_back(e);
   endtask

   task automatic go_b(input logic [7:0] tx, input logic [7:0] exp_rx);
      exp_t e;
      @(negedge clk);
      tx_b = tx; start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      e.rx = exp_rx; e.cyc = cyc + LAT_B;
      sb_b.push_back(e);
   endtask

   task automatic wait_idle_a();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sb_a.size() == 0 && !busy_a) return;
      end
      check("a_timeout_pending", sb_a.size(), 0);
   endtask

   task automatic wait_idle_b();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sb_b.size() == 0 && !busy_b) return;
      end
      check("b_timeout_pending", sb_b.size(), 0);
   endtask

   task automatic wait_cycle(input int target);
      for (int i = 0; i < 400; i++) begin
         if (cyc >= target) return;
         @(negedge clk);
      end
      check("wait_cycle_timeout", cyc, target);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_ld"}, ld_a, 8'h00);
      check({pfx, "_b0"}, b0_a, 1);
      check({pfx, "_clkseq"}, clk_seq_a, 0);
      check({pfx, "_cs"}, cs_a, 1);
      check({pfx, "_busy"}, busy_a, 0);
      check({pfx, "_done"}, done_a, 0);
      check({pfx, "_rx"}, rx_a, 8'h00);
   endtask

   initial begin
      int         n0;
      exp_t       e;
      logic [7:0] pat;

      #23;
      check_reset_vals("rst");
      check("rst_b_b0", b0_b, 1);
      check("rst_b_cs", cs_b, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // loopback 0xA5 with a stray start mid-transfer
      miso_mode = 0;
      go_a(8'hA5, 8'hA5, n0);
      repeat (10) @(negedge clk);
      tx_a = 8'h5A; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_idle_a();
      repeat (3) @(negedge clk);
      check("ignored_start_busy", busy_a, 0);

      // MISO tied high, then low, tx 0x3C; MOSI order is LSB first
      pat = 8'h3C;
      for (int m = 1; m <= 2; m++) begin
         miso_mode = m;
         mosi_log.delete();
         go_a(pat, (m == 1) ? 8'hFF : 8'h00, n0);
         wait_idle_a();
         check("mosi_count", mosi_log.size(), 8);
         for (int i = 0; i < 8 && i < mosi_log.size(); i++)
            check("mosi_bit", mosi_log[i], pat[i]);
      end

      // back-to-back: start held through the done cycle
      miso_mode = 0;
      @(negedge clk);
      tx_a = 8'h12; start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n0 = cyc;
      tx_a = 8'h34;
      e.rx = 8'h12; e.cyc = n0 + LAT_A;     sb_a.push_back(e);
      e.rx = 8'h34; e.cyc = n0 + 2 * LAT_A + 1; sb_a.push_back(e);
      wait_cycle(n0 + LAT_A + 1);
      start_a = 1'b0;
      wait_idle_a();

      // async reset during SHIFT half-period 7
      go_a(8'hC3, 8'hC3, n0);
      wait_cycle(n0 + 2 + DIV_A + 7 * DIV_A);
      check("mid_shift_cs", cs_a, 0);
      check("mid_shift_busy", busy_a, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      sb_a.delete();
      @(negedge clk);
      check("rst_hold_b0", b0_a, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      go_a(8'h5A, 8'h5A, n0);
      wait_idle_a();

      // CLK_DIV=1 loopback
      go_b(8'h81, 8'h81);
      wait_idle_b();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
